uart_rx: RTL

- UART receiver: the receive-side counterpart of the team's 8N1 UART transmitter.
- Samples the asynchronous serial line `rx` at 16x the baud rate and recovers 8N1 frames: start bit, 8 data bits LSB-first, one stop bit.
- Presents each byte on a parallel output with a one-clock valid strobe; flags bad stop bits.
- Sits between the board RX pin and the host-side byte consumer; runs on the system clock, no derived clock domain.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART blocks: receiver state encoding, frame
// constants and the helper that derives the baud tick divider from the
// clock frequency, baud rate and oversampling factor.
`timescale 1ps/1ps
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Clocks per sample tick; integer division, so the real baud rate is
    // slightly above the nominal one when the ratio is not exact.
    function automatic int calcDiv(input int clkFreq, input int baud, input int oversample);
        return clkFreq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running divider producing a single-clock enable pulse every DIV
// clocks. Used as a clock enable rather than a derived clock, so that
// everything downstream stays in the system clock domain.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (counter back to 0)
//   tick_o  one-clock pulse when the counter wraps from DIV-1 to 0
`timescale 1ps/1ps
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    // A divider of 1 still needs a one-bit counter; it simply never leaves 0
    // and the tick is then permanently asserted.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        tick_o  = 1'b0;
        if (count_q == CNT_LAST) begin
            count_d = '0;
            tick_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. Oversamples the asynchronous rx line, recovers start,
// eight data bits (LSB first) and stop bit, and presents each good byte with
// a one-clock strobe. A low stop bit produces a one-clock framing error pulse
// and leaves the output byte untouched.
//
// Ports:
//   clk     system clock, all logic on its rising edge
//   rst     synchronous active-high reset
//   rx      asynchronous serial input, idle high
//   dout    last correctly framed byte
//   dvalid  one-clock pulse, dout updated this cycle
//   ferr    one-clock pulse, stop bit sampled low
//   busy    high while a frame is in progress
`timescale 1ps/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV        = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dvalid,
    output logic       ferr,
    output logic       busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS + 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    logic                 tick;
    logic                 rxMeta_q;
    logic                 rxSync_q;
    rx_state_e            state_q,     state_d;
    logic [SCNT_W-1:0]    sampleCnt_q, sampleCnt_d;
    logic [BCNT_W-1:0]    bitCnt_q,    bitCnt_d;
    logic [DATA_BITS-1:0] shiftReg_q,  shiftReg_d;
    logic [DATA_BITS-1:0] dout_q,      dout_d;
    logic                 dvalid_q,    dvalid_d;
    logic                 ferr_q,      ferr_d;
    logic                 busy_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    // Two-flop synchronizer; reset to the idle level so that leaving reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // The start bit is confirmed half a bit in; from there a full bit period
    // of ticks lands every later decision in the middle of its bit. The stop
    // bit decision returns straight to IDLE so a back-to-back start bit is
    // not missed.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shiftReg_d  = shiftReg_q;
        dout_d      = dout_q;
        dvalid_d    = 1'b0;
        ferr_d      = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        sampleCnt_d = '0;
                        state_d     = START;
                    end
                end
                START: begin
                    if (sampleCnt_q == SCNT_MID) begin
                        sampleCnt_d = '0;
                        if (!rxSync_q) begin
                            bitCnt_d = '0;
                            state_d  = DATA;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (sampleCnt_q == SCNT_LAST) begin
                        shiftReg_d  = {rxSync_q, shiftReg_q[DATA_BITS-1:1]};
                        bitCnt_d    = bitCnt_q + 1'b1;
                        sampleCnt_d = '0;
                        if (bitCnt_q == BCNT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (sampleCnt_q == SCNT_LAST) begin
                        if (rxSync_q) begin
                            dout_d   = shiftReg_q;
                            dvalid_d = 1'b1;
                        end else begin
                            ferr_d   = 1'b1;
                        end
                        sampleCnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // busy is registered from the next state so that it drops on the same
    // edge that raises dvalid or ferr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shiftReg_q  <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shiftReg_q  <= shiftReg_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            ferr_q      <= ferr_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign ferr   = ferr_q;
    assign busy   = busy_q;

endmodule
